// File: rtl/if_id_pipe_if.sv
// Handshake bundle between fetch, the IF/ID stage and decode.
// The slave modport is the pipeline stage; the master modport is the fetch/decode side.
interface if_id_pipe_if #(
  parameter int IW = 32,
  parameter int AW = 32
);
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [IW-1:0] inst_i;
  logic [AW-1:0] instaddr_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [IW-1:0] inst_o;
  logic [AW-1:0] instaddr_o;

  modport slave (
    input  flush_i, in_valid_i, inst_i, instaddr_i, out_ready_i,
    output in_ready_o, out_valid_o, inst_o, instaddr_o
  );

  modport master (
    output flush_i, in_valid_i, inst_i, instaddr_i, out_ready_i,
    input  in_ready_o, out_valid_o, inst_o, instaddr_o
  );
endinterface

// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage with valid/ready handshake, synchronous flush and NOP when empty.
// Define IF_ID_SKID_EN to add a second (skid) entry and a registered in_ready_o.
module if_id_pipe #(
  parameter int            IW       = 32,
  parameter int            AW       = 32,
  parameter logic [IW-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rstn,
  if_id_pipe_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        state_r;
  logic          out_valid_r;
  logic [IW-1:0] inst_r;
  logic [AW-1:0] addr_r;
  logic          in_ready_s;
  logic          accept_s;
  logic          pop_s;

`ifdef IF_ID_SKID_EN
  logic          in_ready_r;
  logic [IW-1:0] skid_inst_r;
  logic [AW-1:0] skid_addr_r;
`endif

  // Handshake qualifiers; with the skid entry ready comes purely from a register.
  always_comb begin
`ifdef IF_ID_SKID_EN
    in_ready_s = in_ready_r;
`else
    in_ready_s = !out_valid_r || bus.out_ready_i;
`endif
    accept_s = bus.in_valid_i && in_ready_s;
    pop_s    = out_valid_r && bus.out_ready_i;
  end

  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = out_valid_r;
  assign bus.inst_o      = inst_r;
  assign bus.instaddr_o  = addr_r;

  // Occupancy FSM; inst_r is forced to NOP whenever the stage becomes empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      inst_r      <= NOP_INST;
      addr_r      <= {AW{1'b0}};
`ifdef IF_ID_SKID_EN
      in_ready_r  <= 1'b1;
      skid_inst_r <= {IW{1'b0}};
      skid_addr_r <= {AW{1'b0}};
`endif
    end else if (bus.flush_i) begin
      // Flush wins over accept and pop; the address output keeps its last value.
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      inst_r      <= NOP_INST;
`ifdef IF_ID_SKID_EN
      in_ready_r  <= 1'b1;
`endif
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r     <= ST_ONE;
            out_valid_r <= 1'b1;
            inst_r      <= bus.inst_i;
            addr_r      <= bus.instaddr_i;
          end else begin
            state_r     <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && pop_s) begin
            inst_r      <= bus.inst_i;
            addr_r      <= bus.instaddr_i;
          end else if (pop_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            inst_r      <= NOP_INST;
`ifdef IF_ID_SKID_EN
          end else if (accept_s) begin
            state_r     <= ST_FULL;
            in_ready_r  <= 1'b0;
            skid_inst_r <= bus.inst_i;
            skid_addr_r <= bus.instaddr_i;
`endif
          end else begin
            state_r     <= ST_ONE;
          end
        end
`ifdef IF_ID_SKID_EN
        ST_FULL: begin
          if (pop_s) begin
            state_r     <= ST_ONE;
            in_ready_r  <= 1'b1;
            inst_r      <= skid_inst_r;
            addr_r      <= skid_addr_r;
          end else begin
            state_r     <= ST_FULL;
          end
        end
`endif
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
          inst_r      <= NOP_INST;
`ifdef IF_ID_SKID_EN
          in_ready_r  <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed self-checking bench for if_id_pipe; expectations follow IF_ID_SKID_EN when defined.
module tb_if_id_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  if_id_pipe_if #(.IW(32), .AW(32)) bus ();

  if_id_pipe #(.IW(32), .AW(32), .NOP_INST(NOP)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic flush, input logic vld, input logic [31:0] inst,
                       input logic [31:0] addr, input logic rdy);
    bus.flush_i     = flush;
    bus.in_valid_i  = vld;
    bus.inst_i      = inst;
    bus.instaddr_i  = addr;
    bus.out_ready_i = rdy;
  endtask

  task automatic expect_out(input string tag, input logic vld, input logic [31:0] inst,
                            input logic [31:0] addr);
    check({tag, "_valid"}, {63'd0, bus.out_valid_o}, {63'd0, vld});
    check({tag, "_inst"},  {32'd0, bus.inst_o},      {32'd0, inst});
    check({tag, "_addr"},  {32'd0, bus.instaddr_o},  {32'd0, addr});
  endtask

  task automatic expect_rdy(input string tag, input logic rdy);
    check({tag, "_in_ready"}, {63'd0, bus.in_ready_o}, {63'd0, rdy});
  endtask

  logic [31:0] stream_inst [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    stream_inst[0] = 32'h0010_0093;
    stream_inst[1] = 32'h0020_0093;
    stream_inst[2] = 32'h0030_0093;
    stream_inst[3] = 32'h0040_0093;
    stream_inst[4] = 32'h0050_0093;

    // Reset with random inputs
    rstn = 1'b0;
    drive(1'b0, 1'($urandom), $urandom, $urandom, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      drive(1'b0, 1'($urandom), $urandom, $urandom, 1'b1);
    end
    expect_out("rst_hold", 1'b0, NOP, 32'h0);
    expect_rdy("rst_hold", 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    rstn = 1'b1;
    tick();
    expect_out("rst_rel", 1'b0, NOP, 32'h0);
    expect_rdy("rst_rel", 1'b1);

    // Streaming, decode always ready
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, stream_inst[i], 32'(i * 4), 1'b1);
      tick();
      expect_out($sformatf("stream%0d", i), 1'b1, stream_inst[i], 32'(i * 4));
      expect_rdy($sformatf("stream%0d", i), 1'b1);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    expect_out("stream_drain", 1'b0, NOP, 32'h10);

    // Backpressure: A held, B offered while decode stalls
    drive(1'b0, 1'b1, 32'h0AAA_0093, 32'h40, 1'b1);
    tick();
    expect_out("bp_a", 1'b1, 32'h0AAA_0093, 32'h40);
    drive(1'b0, 1'b1, 32'h0BBB_0093, 32'h44, 1'b0);
    #1;
`ifdef IF_ID_SKID_EN
    expect_rdy("bp_one", 1'b1);
    tick();
    expect_out("bp_full", 1'b1, 32'h0AAA_0093, 32'h40);
    expect_rdy("bp_full", 1'b0);
    drive(1'b0, 1'b1, 32'h0CCC_0093, 32'h48, 1'b0);
    tick();
    expect_out("bp_hold", 1'b1, 32'h0AAA_0093, 32'h40);
    expect_rdy("bp_hold", 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    expect_out("bp_drain_b", 1'b1, 32'h0BBB_0093, 32'h44);
    expect_rdy("bp_drain_b", 1'b1);
    tick();
    expect_out("bp_empty", 1'b0, NOP, 32'h44);
`else
    expect_rdy("bp_stall", 1'b0);
    tick();
    expect_out("bp_hold", 1'b1, 32'h0AAA_0093, 32'h40);
    expect_rdy("bp_hold", 1'b0);
    bus.out_ready_i = 1'b1;
    #1;
    expect_rdy("bp_release", 1'b1);
    tick();
    expect_out("bp_b", 1'b1, 32'h0BBB_0093, 32'h44);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    expect_out("bp_empty", 1'b0, NOP, 32'h44);
`endif

    // Flush with an offered instruction at 0x20 (FULL with skid, ONE without)
    drive(1'b0, 1'b1, 32'h0111_0093, 32'h30, 1'b1);
    tick();
    drive(1'b0, 1'b1, 32'h0222_0093, 32'h34, 1'b0);
    tick();
    expect_out("fl_pre", 1'b1, 32'h0111_0093, 32'h30);
    drive(1'b1, 1'b1, 32'h0999_0093, 32'h20, 1'b0);
    tick();
    expect_out("fl_post", 1'b0, NOP, 32'h30);
    expect_rdy("fl_post", 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    expect_out("fl_idle1", 1'b0, NOP, 32'h30);
    tick();
    expect_out("fl_idle2", 1'b0, NOP, 32'h30);

    // Back-to-back flushes, each offering an instruction
    drive(1'b0, 1'b1, 32'h0333_0093, 32'h38, 1'b1);
    tick();
    expect_out("bb_load", 1'b1, 32'h0333_0093, 32'h38);
    drive(1'b1, 1'b1, 32'h0444_0093, 32'h3C, 1'b1);
    tick();
    expect_out("bb_fl1", 1'b0, NOP, 32'h38);
    drive(1'b1, 1'b1, 32'h0555_0093, 32'h24, 1'b1);
    tick();
    expect_out("bb_fl2", 1'b0, NOP, 32'h38);
    expect_rdy("bb_fl2", 1'b1);
    drive(1'b0, 1'b1, 32'h0666_0093, 32'h60, 1'b1);
    tick();
    expect_out("bb_resume", 1'b1, 32'h0666_0093, 32'h60);

    // Mid-operation asynchronous reset (FULL with skid, ONE without)
    drive(1'b0, 1'b1, 32'h0777_0093, 32'h50, 1'b1);
    tick();
    drive(1'b0, 1'b1, 32'h0888_0093, 32'h54, 1'b0);
    tick();
    expect_out("mr_pre", 1'b1, 32'h0777_0093, 32'h50);
    #2;
    rstn = 1'b0;
    #1;
    expect_out("mr_async", 1'b0, NOP, 32'h0);
    expect_rdy("mr_async", 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    rstn = 1'b1;
    tick();
    expect_out("mr_after", 1'b0, NOP, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
